// File: rtl/term_switch_matrix_cfg.sv
// Configurable top-edge terminating switch matrix: each northbound wire group is
// looped back southbound with index reversal, under a per-group runtime mode
// loaded through a serial shadow/active configuration chain.

// One wire group: reversal, capture register and mode select.
module term_switch_group #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   mode,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    localparam logic [1:0] MODE_PASS   = 2'b00;
    localparam logic [1:0] MODE_REG    = 2'b01;
    localparam logic [1:0] MODE_ZERO   = 2'b10;
    localparam logic [1:0] MODE_FREEZE = 2'b11;

    logic [W-1:0] pipe;
    logic [W-1:0] rev_in;
    logic [W-1:0] rev_pipe;

    // Capture every cycle except in FREEZE, so REG never shows stale data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe <= '0;
        end else if (mode != MODE_FREEZE) begin
            pipe <= din;
        end
    end

    // Index reversal of the live input and of the captured value.
    always_comb begin
        rev_in   = '0;
        rev_pipe = '0;
        for (int unsigned i = 0; i < W; i++) begin
            rev_in[i]   = din[W-1-i];
            rev_pipe[i] = pipe[W-1-i];
        end
    end

    // Output select by mode.
    always_comb begin
        dout = rev_in;
        case (mode)
            MODE_PASS:   dout = rev_in;
            MODE_REG:    dout = rev_pipe;
            MODE_ZERO:   dout = '0;
            MODE_FREEZE: dout = rev_pipe;
            default:     dout = rev_in;
        endcase
    end

endmodule

// Top: config chain plus the five wire groups.
module term_switch_matrix_cfg #(
    parameter int unsigned W1   = 4,
    parameter int unsigned W2   = 8,
    parameter int unsigned W4   = 16,
    parameter int unsigned WNN4 = 16
) (
    input  logic            UserCLK,
    input  logic            RESETn,
    input  logic [W1-1:0]   N1END,
    input  logic [W2-1:0]   N2MID,
    input  logic [W2-1:0]   N2END,
    input  logic [W4-1:0]   N4END,
    input  logic [WNN4-1:0] NN4END,
    output logic [W1-1:0]   S1BEG,
    output logic [W2-1:0]   S2BEG,
    output logic [W2-1:0]   S2BEGb,
    output logic [W4-1:0]   S4BEG,
    output logic [WNN4-1:0] SS4BEG,
    input  logic            ConfigShiftEn,
    input  logic            ConfigShiftIn,
    input  logic            ConfigCommit,
    output logic            ConfigShiftOut,
    output logic [9:0]      ActiveMode
);

    localparam int unsigned NG    = 5;
    localparam int unsigned CFG_W = 2 * NG;

    logic [CFG_W-1:0] shadow;
    logic [CFG_W-1:0] active;

    // Shadow shift and commit; commit samples the pre-shift shadow.
    always_ff @(posedge UserCLK) begin
        if (!RESETn) begin
            shadow <= '0;
            active <= '0;
        end else begin
            if (ConfigCommit) begin
                active <= shadow;
            end
            if (ConfigShiftEn) begin
                shadow <= {ConfigShiftIn, shadow[CFG_W-1:1]};
            end
        end
    end

    assign ConfigShiftOut = shadow[0];
    assign ActiveMode     = active;

    term_switch_group #(.W(W1)) u_g0 (
        .clk(UserCLK), .rst_n(RESETn), .mode(active[1:0]), .din(N1END), .dout(S1BEG)
    );
    term_switch_group #(.W(W2)) u_g1 (
        .clk(UserCLK), .rst_n(RESETn), .mode(active[3:2]), .din(N2MID), .dout(S2BEG)
    );
    term_switch_group #(.W(W2)) u_g2 (
        .clk(UserCLK), .rst_n(RESETn), .mode(active[5:4]), .din(N2END), .dout(S2BEGb)
    );
    term_switch_group #(.W(W4)) u_g3 (
        .clk(UserCLK), .rst_n(RESETn), .mode(active[7:6]), .din(N4END), .dout(S4BEG)
    );
    term_switch_group #(.W(WNN4)) u_g4 (
        .clk(UserCLK), .rst_n(RESETn), .mode(active[9:8]), .din(NN4END), .dout(SS4BEG)
    );

endmodule

// File: tb/tb_term_switch_matrix_cfg.sv
// Directed self-checking bench for term_switch_matrix_cfg.
module tb_term_switch_matrix_cfg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  n1;
    logic [7:0]  n2mid;
    logic [7:0]  n2end;
    logic [15:0] n4;
    logic [15:0] nn4;
    logic [3:0]  s1;
    logic [7:0]  s2;
    logic [7:0]  s2b;
    logic [15:0] s4;
    logic [15:0] ss4;
    logic        shift_en;
    logic        shift_in;
    logic        commit;
    logic        shift_out;
    logic [9:0]  active_mode;

    int n_assert = 0;
    int n_fail   = 0;
    logic [9:0] word;

    always #5 clk = ~clk;

    term_switch_matrix_cfg dut (
        .UserCLK(clk), .RESETn(rst_n),
        .N1END(n1), .N2MID(n2mid), .N2END(n2end), .N4END(n4), .NN4END(nn4),
        .S1BEG(s1), .S2BEG(s2), .S2BEGb(s2b), .S4BEG(s4), .SS4BEG(ss4),
        .ConfigShiftEn(shift_en), .ConfigShiftIn(shift_in), .ConfigCommit(commit),
        .ConfigShiftOut(shift_out), .ActiveMode(active_mode)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bit 0 goes in first so it lands in shadow[0] after ten shifts.
    task automatic shift_word(input logic [9:0] v);
        for (int i = 0; i < 10; i++) begin
            shift_en = 1'b1;
            shift_in = v[i];
            tick();
        end
        shift_en = 1'b0;
        shift_in = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; n1 = '0; n2mid = '0; n2end = '0; n4 = '0; nn4 = '0;
        shift_en = 1'b0; shift_in = 1'b0; commit = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset state and PASS reversal
        chk("rst_active", 32'(active_mode), 32'h0);
        chk("rst_shout", 32'(shift_out), 32'h0);
        n1 = 4'b0001; n4 = 16'h0001; n2mid = 8'h01;
        #1;
        chk("pass_s1", 32'(s1), 32'h8);
        chk("pass_s4", 32'(s4), 32'h8000);
        chk("pass_s2", 32'(s2), 32'h80);

        // Group0 REG
        shift_word(10'h001);
        do_commit();
        chk("reg_active", 32'(active_mode), 32'h001);
        n1 = 4'h3;
        #1;
        chk("reg_s1_t", 32'(s1), 32'h8);
        tick();
        chk("reg_s1_t1", 32'(s1), 32'hC);
        n2end = 8'h0F;
        #1;
        chk("reg_other_comb", 32'(s2b), 32'hF0);

        // Group3 FREEZE
        n4 = 16'h00F0;
        shift_word(10'h0C0);
        do_commit();
        chk("frz_active", 32'(active_mode), 32'h0C0);
        n4 = 16'hFFFF;
        #1;
        chk("frz_s4", 32'(s4), 32'h0F00);
        tick();
        chk("frz_s4_hold", 32'(s4), 32'h0F00);
        shift_word(10'h000);
        do_commit();
        chk("unfrz_s4", 32'(s4), 32'hFFFF);
        n4 = 16'h0001;
        #1;
        chk("unfrz_s4_comb", 32'(s4), 32'h8000);

        // Group4 ZERO, then shift-out delay check
        nn4 = 16'hFFFF;
        shift_word(10'h200);
        do_commit();
        chk("zero_ss4", 32'(ss4), 32'h0);
        word = 10'h200;
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("shout_%0d", k), 32'(shift_out), 32'(word[k]));
            shift_en = 1'b1;
            shift_in = (k == 6 || k == 7) ? 1'b1 : 1'b0;
            tick();
        end
        shift_en = 1'b0;
        shift_in = 1'b0;

        // Same-cycle shift and commit; shadow now 0x0C0
        shift_en = 1'b1; shift_in = 1'b1; commit = 1'b1;
        tick();
        shift_en = 1'b0; shift_in = 1'b0; commit = 1'b0;
        chk("sc_active", 32'(active_mode), 32'h0C0);
        do_commit();
        chk("sc_shadow", 32'(active_mode), 32'h260);

        // Reset while group2 is FREEZE
        n2end = 8'h0F;
        shift_word(10'h030);
        do_commit();
        n2end = 8'h03;
        #1;
        chk("frz2_s2b", 32'(s2b), 32'hF0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst2_active", 32'(active_mode), 32'h0);
        chk("rst2_shout", 32'(shift_out), 32'h0);
        chk("rst2_s2b", 32'(s2b), 32'hC0);
        n2end = 8'h01;
        #1;
        chk("rst2_s2b_comb", 32'(s2b), 32'h80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
